// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with a double-buffered frame word.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  input  logic        enable,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        frame_done
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [31:0]     pending_q;
  logic [31:0]     frame_q;
  logic [7:0]      an_q;
  logic [7:0]      seg_q;

  logic       tick;
  logic       wrap;
  logic       blank;
  logic [3:0] nib;
  logic [6:0] seg_lo;
  logic [7:0] an_d;
  logic [7:0] seg_d;

  assign tick       = enable && (cnt_q == CntLast);
  assign wrap       = tick && (idx_q == 3'd7);
  assign frame_done = wrap;
  assign AN         = an_q;
  assign SEG        = seg_q;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  logic [2:0] top;

  // Highest non-zero nibble; digit 0 stays lit even for an all-zero word.
  always_comb begin
    top = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (frame_q[4*i +: 4] != 4'h0) top = 3'(i);
    end
  end

  assign blank = (idx_q > top);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    nib    = frame_q[{idx_q, 2'b00} +: 4];
    seg_lo = dec7(nib);
    an_d   = 8'hFF;
    seg_d  = 8'hFF;
    if (enable && !blank) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = {~dp_mask[idx_q], seg_lo};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      pending_q <= 32'h0;
      frame_q   <= 32'h0;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
    end else begin
      if (enable) begin
        cnt_q <= tick ? '0 : cnt_q + CntW'(1);
        if (tick) idx_q <= idx_q + 3'd1;
      end
      if (load) pending_q <= data_in;
      // A load landing on the wrap bypasses pending so the new frame shows it at once.
      if (wrap) frame_q <= load ? data_in : pending_q;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a cycle-count based display model checked every
// cycle, plus directed literal checks. Honours SEG7_LZ_BLANK_EN like the design.
module tb_seg7_scan_driver;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_mask;
  logic        enable;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .dp_mask    (dp_mask),
    .enable     (enable),
    .AN         (AN),
    .SEG        (SEG),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  // {AN, SEG} for a digit of a word when enabled.
  function automatic logic [15:0] show(input int digit, input logic [31:0] word,
                                       input logic [7:0] dp);
    int top = 0;
    for (int i = 0; i < 8; i++) if (word[4*i +: 4] != 4'h0) top = i;
`ifdef SEG7_LZ_BLANK_EN
    if (digit > top) return 16'hFFFF;
`endif
    return {~(8'd1 << digit), ~dp[digit], dec7(word[4*digit +: 4])};
  endfunction

  // Model: digit slot derived from the number of enabled cycles since reset.
  int unsigned m_en   = 0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] m_frame = 32'h0;
  logic [7:0]  m_an   = 8'hFF;
  logic [7:0]  m_seg  = 8'hFF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en    = 0;
      m_pend  = 32'h0;
      m_frame = 32'h0;
      m_an    = 8'hFF;
      m_seg   = 8'hFF;
    end else begin
      int   digit;
      logic wrap;
      digit = int'((m_en / D) % 8);
      {m_an, m_seg} = enable ? show(digit, m_frame, dp_mask) : 16'hFFFF;
      wrap = enable && (m_en % D == D - 1) && (digit == 7);
      if (wrap) m_frame = load ? data_in : m_pend;
      if (load) m_pend = data_in;
      if (enable) m_en++;
    end
  end

  logic fd_exp;
  assign fd_exp = enable && !rst && (m_en % D == D - 1) && ((m_en / D) % 8 == 7);

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_an", {24'h0, AN}, {24'h0, m_an});
      check("model_seg", {24'h0, SEG}, {24'h0, m_seg});
      check("model_frame_done", {31'h0, frame_done}, {31'h0, fd_exp});
    end
  end

  task automatic wait_an(input logic [7:0] v);
    int k = 0;
    @(negedge clk);
    while (AN !== v && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (AN !== v) check("wait_an_timeout", {24'h0, AN}, {24'h0, v});
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 500);
    if (!frame_done) check("wait_fd_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_word(input logic [31:0] w);
    @(posedge clk); #1;
    data_in = w;
    load    = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
  endtask

  logic [7:0] exp2 [8];
  int n;

  initial begin
    exp2 = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    rst = 1'b1; load = 1'b0; enable = 1'b1; data_in = 32'h0; dp_mask = 8'h00;

    // Reset values and first cycle after release
    @(negedge clk);
    chk_on = 1'b1;
    check("rst_an", {24'h0, AN}, 32'hFF);
    check("rst_seg", {24'h0, SEG}, 32'hFF);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_an", {24'h0, AN}, 32'hFE);
    check("post_rst_seg", {24'h0, SEG}, 32'hC0);

    // frame_done period
    wait_fd(n);
    wait_fd(n);
    check("fd_period", n, 32'd32);

    // Full frame of 1234ABCD
    load_word(32'h1234ABCD);
    wait_fd(n);
    wait_an(8'hFE);
    for (int k = 0; k < 8; k++) begin
      check("w1234_seg", {24'h0, SEG}, {24'h0, exp2[k]});
      check("w1234_an", {24'h0, AN}, {24'h0, ~(8'd1 << k)});
      repeat (D) @(negedge clk);
    end

    // Mid-frame load does not tear the current frame
    wait_an(8'hF7);
    data_in = 32'hFFFFFFFF; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    wait_an(8'hDF);
    check("midload_old_d5", {24'h0, SEG}, 32'hB0);
    wait_an(8'hFE);
    check("midload_new_d0", {24'h0, SEG}, 32'h8E);
    wait_an(8'h7F);
    check("midload_new_d7", {24'h0, SEG}, 32'h8E);

    // Load coinciding with the wrap tick bypasses pending
    wait_fd(n);
    data_in = 32'h5; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    wait_an(8'hFE);
    check("bypass_d0", {24'h0, SEG}, 32'h92);
    wait_an(8'hFD);
    check("bypass_d1", {24'h0, SEG}, 32'hC0);

    // Decimal point and enable hold
    load_word(32'h0);
    dp_mask = 8'h04;
    wait_fd(n);
    wait_an(8'hFB);
    check("dp_d2", {24'h0, SEG}, 32'h40);
    wait_an(8'hF7);
    check("dp_d3", {24'h0, SEG}, 32'hC0);
    @(posedge clk); #1 enable = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("dis_an", {24'h0, AN}, 32'hFF);
    check("dis_seg", {24'h0, SEG}, 32'hFF);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); @(negedge clk);
    check("resume_an", {24'h0, AN}, 32'hF7);
    dp_mask = 8'h00;

    // Leading-zero behaviour
    load_word(32'h000000A0);
    wait_fd(n);
    wait_an(8'hFE);
    check("lz_d0_seg", {24'h0, SEG}, 32'hC0);
    repeat (D) @(negedge clk);
    check("lz_d1_seg", {24'h0, SEG}, 32'h88);
    repeat (D) @(negedge clk);
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d2_an", {24'h0, AN}, 32'hFF);
    check("lz_d2_seg", {24'h0, SEG}, 32'hFF);
`else
    check("lz_d2_an", {24'h0, AN}, 32'hFB);
    check("lz_d2_seg", {24'h0, SEG}, 32'hC0);
`endif
    load_word(32'h0);
    wait_fd(n);
    wait_an(8'hFE);
    check("zero_d0_seg", {24'h0, SEG}, 32'hC0);
    repeat (D) @(negedge clk);
`ifdef SEG7_LZ_BLANK_EN
    check("zero_d1_an", {24'h0, AN}, 32'hFF);
`else
    check("zero_d1_an", {24'h0, AN}, 32'hFD);
`endif

    // Reset mid-frame
    wait_an(8'hEF);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_an", {24'h0, AN}, 32'hFF);
    check("midrst_seg", {24'h0, SEG}, 32'hFF);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_rel_an", {24'h0, AN}, 32'hFE);
    check("midrst_rel_seg", {24'h0, SEG}, 32'hC0);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
